// File: rtl/inst_fetch_queue_pkg.sv
// inst_fetch_queue_pkg: shared constants, fetch state encodings and J-immediate decode.
package inst_fetch_queue_pkg;
    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;
    localparam logic HIGH  = 1'b1;
    localparam logic LOW   = 1'b0;
    localparam logic [6:0] OPC_JAL = 7'b1101111;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_WAIT = 2'd1,
        IF_DROP = 2'd2
    } if_state_e;

    function automatic logic [20:0] j_imm(input logic [31:0] inst);
        return {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction
endpackage

// File: rtl/inst_fetch_queue_fetch_fifo.sv
// fetch_fifo: DEPTH-entry circular buffer with flush (priority), push, pop and occupancy count.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     en_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             wdata_i,
    output logic [W-1:0]             rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign do_push = en_i && push_i && !flush_i;
    assign do_pop  = en_i && pop_i && !flush_i && (count_q != '0);

    // next pointers and count: flush clears everything, otherwise push/pop advance independently
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (en_i && flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = do_pop  ? head_q + AW'(1) : head_q;
            tail_d  = do_push ? tail_q + AW'(1) : tail_q;
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // pointer and count registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // entry storage needs no reset; validity is tracked by count
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[tail_q] <= wdata_i;
    end

    assign rdata_o = mem_q[head_q];
    assign count_o = count_q;
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: PC generator issuing one outstanding I-cache request at a time and
// buffering PC-tagged instructions for decode; jumps flush the queue and squash in-flight data.
// Optional JAL next-PC prediction with a per-entry pred_taken bit: define IF_JAL_PREDICT_EN.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    output logic            pc_send_enable,
    output logic [XLEN-1:0] pc_to_ic,
    input  logic            inst_get_ready,
    input  logic [XLEN-1:0] inst_from_ic,
    input  logic            jump_flag,
    input  logic [XLEN-1:0] target_pc,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst_to_dec,
    output logic [XLEN-1:0] pc_to_dec,
    input  logic            dec_ready,
`ifdef IF_JAL_PREDICT_EN
    output logic            pred_taken_to_dec,
`endif
    output logic            queue_full
);
    localparam int AW = $clog2(DEPTH);
`ifdef IF_JAL_PREDICT_EN
    localparam int EW = 2 * XLEN + 1;
`else
    localparam int EW = 2 * XLEN;
`endif

    if_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, req_pc_q, req_pc_d, next_pc;
    logic            send_q, send_d, push, empty;
    logic [AW:0]     count;
    logic [EW-1:0]   wdata, rdata;

`ifdef IF_JAL_PREDICT_EN
    logic [20:0] imm;
    logic        is_jal;
    assign imm     = j_imm(inst_from_ic[31:0]);
    assign is_jal  = (inst_from_ic[6:0] == OPC_JAL);
    assign next_pc = is_jal ? pc_q + {{(XLEN-21){imm[20]}}, imm} : pc_q + XLEN'(4);
    assign wdata   = {is_jal, pc_q, inst_from_ic};
    assign {pred_taken_to_dec, pc_to_dec, inst_to_dec} = rdata;
`else
    assign next_pc = pc_q + XLEN'(4);
    assign wdata   = {pc_q, inst_from_ic};
    assign {pc_to_dec, inst_to_dec} = rdata;
`endif

    // fetch FSM: a jump overrides everything; an unanswered request at jump time must be drained in DROP
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        send_d   = send_q;
        push     = FALSE;
        if (rdy) begin
            if (jump_flag) begin
                pc_d    = target_pc;
                send_d  = LOW;
                state_d = (state_q != IF_IDLE && !inst_get_ready) ? IF_DROP : IF_IDLE;
            end else if (state_q == IF_IDLE) begin
                if (count < (AW+1)'(DEPTH)) begin
                    req_pc_d = pc_q;
                    send_d   = HIGH;
                    state_d  = IF_WAIT;
                end
            end else if (inst_get_ready) begin
                send_d  = LOW;
                state_d = IF_IDLE;
                if (state_q == IF_WAIT) begin
                    push = TRUE;
                    pc_d = next_pc;
                end
            end
        end
    end

    // fetch state, PC and request registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IF_IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            send_q   <= LOW;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            send_q   <= send_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .en_i    (rdy),
        .flush_i (jump_flag),
        .push_i  (push),
        .pop_i   (dec_ready),
        .wdata_i (wdata),
        .rdata_o (rdata),
        .count_o (count),
        .full_o  (queue_full),
        .empty_o (empty)
    );

    assign pc_send_enable = send_q;
    assign pc_to_ic       = req_pc_q;
    assign inst_valid     = !empty;
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: directed scoreboard bench for the fetch queue (optionally with IF_JAL_PREDICT_EN).
module tb_inst_fetch_queue;
    logic        clk = 1'b0;
    logic        rst, rdy, pc_send_enable, inst_get_ready, jump_flag, inst_valid, dec_ready, queue_full;
    logic [31:0] pc_to_ic, inst_from_ic, target_pc, inst_to_dec, pc_to_dec;
`ifdef IF_JAL_PREDICT_EN
    logic        pred_taken_to_dec;
`endif
    int          tests = 0;
    int          fails = 0;
    logic [64:0] sb[$];
    logic [31:0] exp_pc;

    always #5 clk = ~clk;

    inst_fetch_queue dut (
        .clk               (clk),
        .rst               (rst),
        .rdy               (rdy),
        .pc_send_enable    (pc_send_enable),
        .pc_to_ic          (pc_to_ic),
        .inst_get_ready    (inst_get_ready),
        .inst_from_ic      (inst_from_ic),
        .jump_flag         (jump_flag),
        .target_pc         (target_pc),
        .inst_valid        (inst_valid),
        .inst_to_dec       (inst_to_dec),
        .pc_to_dec         (pc_to_dec),
        .dec_ready         (dec_ready),
`ifdef IF_JAL_PREDICT_EN
        .pred_taken_to_dec (pred_taken_to_dec),
`endif
        .queue_full        (queue_full)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one clock: check any handshake pop against the scoreboard, then advance and clear pulses
    task automatic cyc();
        logic [64:0] e;
        if (rdy && inst_valid && dec_ready && !jump_flag) begin
            chk("pop_avail", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("dec_pc", 64'(pc_to_dec), 64'(e[63:32]));
                chk("dec_inst", 64'(inst_to_dec), 64'(e[31:0]));
`ifdef IF_JAL_PREDICT_EN
                chk("dec_pred", 64'(pred_taken_to_dec), 64'(e[64]));
`endif
            end
        end
        @(posedge clk);
        #1;
        inst_get_ready = 1'b0;
        jump_flag      = 1'b0;
    endtask

    // wait for a request, hold it d cycles, answer with inst and record the expected entry
    task automatic serve(input logic [31:0] inst, input int d);
        int          n;
        logic        p;
        logic [31:0] nxt;
        n   = 0;
        p   = 1'b0;
        nxt = exp_pc + 32'd4;
`ifdef IF_JAL_PREDICT_EN
        if (inst[6:0] == 7'h6F) begin
            p   = 1'b1;
            nxt = exp_pc + {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        end
`endif
        while (!pc_send_enable && n < 20) begin
            cyc();
            n++;
        end
        chk("req_seen", 64'(pc_send_enable), 64'd1);
        chk("req_pc", 64'(pc_to_ic), 64'(exp_pc));
        repeat (d) begin
            cyc();
            chk("req_hold", 64'({pc_send_enable, pc_to_ic}), 64'({1'b1, exp_pc}));
        end
        inst_get_ready = 1'b1;
        inst_from_ic   = inst;
        sb.push_back({p, exp_pc, inst});
        exp_pc = nxt;
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; rdy = 1'b1; inst_get_ready = 1'b0; jump_flag = 1'b0;
        dec_ready = 1'b1; inst_from_ic = '0; target_pc = '0; exp_pc = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_send", 64'(pc_send_enable), 64'd0);
        chk("rst_pc_ic", 64'(pc_to_ic), 64'd0);
        chk("rst_valid", 64'(inst_valid), 64'd0);
        chk("rst_full", 64'(queue_full), 64'd0);
        rst = 1'b1;

        // streaming with the decoder always ready
        for (int i = 0; i < 4; i++) begin
            serve(32'h1000_0013 | (32'(i) << 20), 1);
            chk("push_valid", 64'(inst_valid), 64'd1);
            chk("gap_idle", 64'(pc_send_enable), 64'd0);
            cyc();
            chk("reissue", 64'(pc_send_enable), 64'd1);
            chk("reissue_pc", 64'(pc_to_ic), 64'(exp_pc));
        end

        // back-pressure until full, then a single pop
        dec_ready = 1'b0;
        for (int i = 0; i < 4; i++) serve(32'h2000_0093 + 32'(i), 0);
        chk("bp_full", 64'(queue_full), 64'd1);
        chk("bp_send", 64'(pc_send_enable), 64'd0);
        repeat (3) begin
            cyc();
            chk("bp_hold_send", 64'(pc_send_enable), 64'd0);
            chk("bp_hold_full", 64'(queue_full), 64'd1);
        end
        chk("bp_head", 64'(pc_to_dec), 64'(sb[0][63:32]));
        dec_ready = 1'b1;
        cyc();
        dec_ready = 1'b0;
        chk("bp_unfull", 64'(queue_full), 64'd0);
        chk("bp_no_issue", 64'(pc_send_enable), 64'd0);
        cyc();
        chk("bp_issue", 64'(pc_send_enable), 64'd1);
        chk("bp_issue_pc", 64'(pc_to_ic), 64'(exp_pc));

        // jump while waiting: drop the late response, second jump while dropping
        jump_flag = 1'b1; target_pc = 32'h100; sb.delete(); exp_pc = 32'h100;
        cyc();
        chk("jmp_flush", 64'(inst_valid), 64'd0);
        chk("drop_send", 64'(pc_send_enable), 64'd0);
        cyc();
        chk("drop_wait", 64'(pc_send_enable), 64'd0);
        jump_flag = 1'b1; target_pc = 32'h180; exp_pc = 32'h180;
        cyc();
        chk("drop_jump", 64'(pc_send_enable), 64'd0);
        inst_get_ready = 1'b1; inst_from_ic = 32'hBAD0_0013;
        cyc();
        chk("drop_discard", 64'(inst_valid), 64'd0);
        chk("drop_idle", 64'(pc_send_enable), 64'd0);
        serve(32'h0000_0093, 1);

        // jump coinciding with a response and a pop
        cyc();
        chk("co_req", 64'(pc_send_enable), 64'd1);
        chk("co_req_pc", 64'(pc_to_ic), 64'(exp_pc));
        inst_get_ready = 1'b1; inst_from_ic = 32'h0000_0113;
        jump_flag = 1'b1; target_pc = 32'h100; dec_ready = 1'b1;
        sb.delete(); exp_pc = 32'h100;
        cyc();
        chk("co_flush", 64'(inst_valid), 64'd0);
        chk("co_send", 64'(pc_send_enable), 64'd0);
        cyc();
        chk("co_reissue", 64'(pc_send_enable), 64'd1);
        chk("co_reissue_pc", 64'(pc_to_ic), 64'h100);

        // rdy freeze mid-WAIT with an entry queued
        dec_ready = 1'b0;
        serve(32'h0000_0193, 0);
        cyc();
        chk("frz_pre", 64'(pc_to_ic), 64'h104);
        rdy = 1'b0; dec_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                inst_get_ready = 1'b1;
                inst_from_ic   = 32'hDEAD_0013;
            end
            cyc();
            chk("frz_send", 64'(pc_send_enable), 64'd1);
            chk("frz_pc_ic", 64'(pc_to_ic), 64'h104);
            chk("frz_valid", 64'(inst_valid), 64'd1);
            chk("frz_head", 64'(pc_to_dec), 64'h100);
        end
        rdy = 1'b1; dec_ready = 1'b0;
        serve(32'h0000_0213, 0);
        chk("thaw_head", 64'(pc_to_dec), 64'h100);

        // asynchronous reset between edges
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ar_send", 64'(pc_send_enable), 64'd0);
        chk("ar_pc_ic", 64'(pc_to_ic), 64'd0);
        chk("ar_valid", 64'(inst_valid), 64'd0);
        chk("ar_full", 64'(queue_full), 64'd0);
        #1;
        rst = 1'b1; sb.delete(); exp_pc = 32'h0; dec_ready = 1'b1;
        @(posedge clk);
        #1;
        serve(32'h0000_0293, 1);

        // PC wrap-around at the top of the address space
        jump_flag = 1'b1; target_pc = 32'hFFFF_FFFC; sb.delete(); exp_pc = 32'hFFFF_FFFC;
        cyc();
        serve(32'h0000_0313, 0);
        cyc();
        chk("wrap_pc", 64'(pc_to_ic), 64'd0);
        serve(32'h0000_0393, 0);

        // JAL at 0x20: next request 0x28 with prediction, 0x24 without
        jump_flag = 1'b1; target_pc = 32'h20; sb.delete(); exp_pc = 32'h20;
        cyc();
        serve(32'h0080_006F, 1);
        cyc();
        chk("jal_req", 64'(pc_send_enable), 64'd1);
        chk("jal_next_pc", 64'(pc_to_ic), 64'(exp_pc));
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
Parametrised successor to the single-slot fetch unit. Generates the PC stream and issues one outstanding request at a time to the I-cache. Buffers returned instructions, each tagged with its PC, in a DEPTH-entry FIFO that the decoder drains with a valid/ready handshake. On a jump it flushes the queue and squashes any in-flight response, so wrong-path instructions never reach decode.

Parameters:
XLEN, 32, PC and instruction width.
DEPTH, 4, queue entries; power of two, at least 2.
RESET_PC, 32'h0, PC value loaded at reset.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset.
rdy  in  1  global enable; when low, all state is frozen.
pc_send_enable  out  1  I-cache request valid.
pc_to_ic  out  XLEN  request address.
inst_get_ready  in  1  I-cache response valid; one-cycle pulse.
inst_from_ic  in  XLEN  response data.
jump_flag  in  1  redirect request from the commit/branch unit.
target_pc  in  XLEN  redirect address.
inst_valid  out  1  queue head is valid.
inst_to_dec  out  XLEN  head instruction.
pc_to_dec  out  XLEN  head PC.
dec_ready  in  1  decoder accepts the head this cycle.
queue_full  out  1  count equals DEPTH (debug/perf).

Behaviour:
- Reset (rst=0, async):
  - pc = RESET_PC; head = tail = count = 0; state = IDLE.
  - pc_send_enable = 0; pc_to_ic = 0; inst_valid = 0.
- rdy=0: no register changes; outputs hold their values; no push or pop.
- State machine (registered):
  - IDLE: if count < DEPTH, drive pc_to_ic <= pc and pc_send_enable <= 1, then go to WAIT. A slot is reserved for the outstanding request, so a response always has room.
  - WAIT: hold pc_send_enable=1 and pc_to_ic stable until inst_get_ready=1. On response: push {pc, inst_from_ic}; pc <= pc+4 (mod 2^XLEN wrap); pc_send_enable <= 0; go to IDLE. Next request issues at the earliest one cycle later (2-cycle minimum issue interval, as in the current design).
  - DROP: entered on jump_flag while in WAIT with no response that cycle. pc_send_enable <= 0. Wait for inst_get_ready, discard the data, go to IDLE.
- Jump (jump_flag=1, rdy=1):
  - Has priority over push and pop in the same cycle.
  - pc <= target_pc; queue flushed (head=tail=count=0); inst_valid drops next cycle.
  - A response arriving in the same cycle as the jump is discarded; go to IDLE, not DROP.
  - A jump while in DROP updates pc only and stays in DROP.
- Dequeue:
  - inst_valid = (count != 0).
  - inst_to_dec and pc_to_dec present the head entry combinationally from registered storage.
  - Pop when inst_valid && dec_ready && !jump_flag.
- Push and pop in the same cycle: count unchanged; pointers advance modulo DEPTH.
- Full: the IDLE→WAIT issue condition is count < DEPTH. A response still in flight always finds a slot, because only one request is outstanding and the issue required a free slot.
- Empty: dec_ready is ignored.
- Widths: count is $clog2(DEPTH)+1 bits; pointers are $clog2(DEPTH) bits.

Optional Feature:
IF_JAL_PREDICT_EN.
- Defined: on push, if inst_from_ic[6:0]==7'b1101111 (JAL), the next pc is pc + sign-extended J-immediate instead of pc+4. Each queue entry carries a pred_taken bit, exposed on an extra output pred_taken_to_dec (1 bit).
- Undefined: the next pc is always pc+4, and the port and bit are absent.

Decomposition:
- Shared package/header (config.v): TRUE/FALSE/HIGH/LOW, opcode constant OPC_JAL, fetch state encodings IF_IDLE/IF_WAIT/IF_DROP.
- One natural sub-module, fetch_fifo: a parametrised DEPTH×(2·XLEN[+1]) circular buffer with flush, push, pop, count, full and empty.
- Fetch FSM and PC logic stay in the top module.

Test Plan:
- Reset and stream: RESET_PC=0, the I-cache responds 2 cycles after each request, dec_ready=1 → decoder sees PCs 0,4,8,12 in order, each paired with its instruction; no gaps beyond the 2-cycle issue interval.
- Back-pressure: dec_ready=0 with DEPTH=4 → after 4 pushes, queue_full=1 and pc_send_enable stays 0. Set dec_ready=1 for one cycle → exactly one pop, then one new request to pc=16.
- Jump during WAIT: request to pc=8 outstanding, jump_flag with target_pc=0x100 → state DROP; the late response for 8 is discarded; the next request is 0x100; queue empty in between.
- Jump coincident with response and pop: all three in the same cycle → nothing pushed, queue flushed, next request 0x100, no DROP.
- rdy freeze and async reset: rdy=0 for 5 cycles mid-WAIT → outputs and count unchanged. Assert rst=0 between clock edges → outputs clear immediately and pc=RESET_PC.
- With IF_JAL_PREDICT_EN: instruction 0x0080006F at pc=0x20 → next request pc=0x28, pred_taken_to_dec=1 for that entry.
